// File: rtl/cl_axil_cmd_master.sv
// cl_axil_cmd_master
// AXI-Lite initiator. Turns a valid/ready command into a single-beat AXI-Lite read or write
// and returns the result on a valid/ready response port. Only one transaction is in flight.
// A response-phase timeout answers the command side with SLVERR. After a timeout, the late
// B/R beat is drained and discarded before the next command is accepted.
//
// Ports
//   clk_main_a0, rst_main_n        : clock and synchronous active-low reset
//   cmd_*                          : command in (write flag, address, data, strobes)
//   rsp_*                          : response out (read data, resp code, timeout flag)
//   busy                           : transaction in progress, or a stale beat is pending
//   m_axi_aw*/w*/b*/ar*/r*         : AXI-Lite master channels
module cl_axil_cmd_master #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_main_a0,
    input  logic                  rst_main_n,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    input  logic [3:0]            cmd_wstrb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout,
    output logic                  busy,

    output logic                  m_axi_awvalid,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    input  logic                  m_axi_awready,
    output logic                  m_axi_wvalid,
    output logic [31:0]           m_axi_wdata,
    output logic [3:0]            m_axi_wstrb,
    input  logic                  m_axi_wready,
    input  logic                  m_axi_bvalid,
    input  logic [1:0]            m_axi_bresp,
    output logic                  m_axi_bready,
    output logic                  m_axi_arvalid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    input  logic                  m_axi_arready,
    input  logic                  m_axi_rvalid,
    input  logic [31:0]           m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    output logic                  m_axi_rready
);

    // A zero timeout still needs a legal one-bit counter.
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CntW-1:0] CntLast =
        (TIMEOUT_CYCLES > 0) ? CntW'(TIMEOUT_CYCLES - 1) : '0;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StWrReq  = 3'd1;
    localparam logic [2:0] StWrResp = 3'd2;
    localparam logic [2:0] StRdReq  = 3'd3;
    localparam logic [2:0] StRdData = 3'd4;
    localparam logic [2:0] StRsp    = 3'd5;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  arvalid_q, arvalid_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [1:0]            resp_q, resp_d;
    logic                  tmo_q, tmo_d;
    logic                  stale_b_q, stale_b_d;
    logic                  stale_r_q, stale_r_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  expire;

    // The counter value seen in the last cycle before expiry is TIMEOUT_CYCLES-1.
    assign expire = (TIMEOUT_CYCLES != 0) && (cnt_q == CntLast);

    assign cmd_ready     = (state_q == StIdle) && !stale_b_q && !stale_r_q;
    assign busy          = (state_q != StIdle) || stale_b_q || stale_r_q;
    assign rsp_valid     = (state_q == StRsp);
    assign rsp_rdata     = rdata_q;
    assign rsp_resp      = resp_q;
    assign rsp_timeout   = tmo_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_araddr  = addr_q;
    // A stale flag keeps the ready up so the late beat gets drained.
    assign m_axi_bready  = (state_q == StWrResp) || stale_b_q;
    assign m_axi_rready  = (state_q == StRdData) || stale_r_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        tmo_d     = tmo_q;
        stale_b_d = stale_b_q;
        stale_r_d = stale_r_q;
        cnt_d     = cnt_q;

        if (stale_b_q && m_axi_bvalid) stale_b_d = 1'b0;
        if (stale_r_q && m_axi_rvalid) stale_r_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    if (cmd_write) begin
                        state_d   = StWrReq;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = StRdReq;
                        arvalid_d = 1'b1;
                    end
                end
            end
            StWrReq: begin
                if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axi_wready) wvalid_d = 1'b0;
                // Each channel is done if it already completed or completes this cycle.
                if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready)) begin
                    state_d = StWrResp;
                    cnt_d   = '0;
                end
            end
            StWrResp: begin
                if (m_axi_bvalid) begin
                    state_d = StRsp;
                    rdata_d = '0;
                    resp_d  = m_axi_bresp;
                    tmo_d   = 1'b0;
                end else if (expire) begin
                    state_d   = StRsp;
                    rdata_d   = '0;
                    resp_d    = 2'b10;
                    tmo_d     = 1'b1;
                    stale_b_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRdReq: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = StRdData;
                    cnt_d     = '0;
                end
            end
            StRdData: begin
                if (m_axi_rvalid) begin
                    state_d = StRsp;
                    rdata_d = m_axi_rdata;
                    resp_d  = m_axi_rresp;
                    tmo_d   = 1'b0;
                end else if (expire) begin
                    state_d   = StRsp;
                    rdata_d   = '0;
                    resp_d    = 2'b10;
                    tmo_d     = 1'b1;
                    stale_r_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRsp: begin
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_main_a0) begin
        if (!rst_main_n) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= '0;
            tmo_q     <= 1'b0;
            stale_b_q <= 1'b0;
            stale_r_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            tmo_q     <= tmo_d;
            stale_b_q <= stale_b_d;
            stale_r_q <= stale_r_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_cl_axil_cmd_master.sv
// Directed bench for cl_axil_cmd_master: table of zero-wait transactions plus hand-written
// sequences for skewed handshakes, timeout/drain, response backpressure and mid-op reset.
module tb_cl_axil_cmd_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout, busy;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cl_axil_cmd_master #(
        .ADDR_WIDTH    (32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_main_a0  (clk),
        .rst_main_n   (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .cmd_wstrb    (cmd_wstrb),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_resp     (rsp_resp),
        .rsp_timeout  (rsp_timeout),
        .busy         (busy),
        .m_axi_awvalid(awvalid),
        .m_axi_awaddr (awaddr),
        .m_axi_awready(awready),
        .m_axi_wvalid (wvalid),
        .m_axi_wdata  (wdata),
        .m_axi_wstrb  (wstrb),
        .m_axi_wready (wready),
        .m_axi_bvalid (bvalid),
        .m_axi_bresp  (bresp),
        .m_axi_bready (bready),
        .m_axi_arvalid(arvalid),
        .m_axi_araddr (araddr),
        .m_axi_arready(arready),
        .m_axi_rvalid (rvalid),
        .m_axi_rdata  (rdata),
        .m_axi_rresp  (rresp),
        .m_axi_rready (rready)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  strb;
        logic [31:0] slv_rdata;  // data the responder returns on R
        logic [1:0]  slv_resp;   // BRESP/RRESP the responder returns
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = s;
        chk("cmd_ready_at_accept", {31'd0, cmd_ready}, 32'd1);
        step();
        cmd_valid = 1'b0;
    endtask

    // Zero-wait responder, checks T+1 request, T+2 response handshake, T+3 rsp_valid.
    task automatic run_vec(input vec_t v);
        issue(v.wr, v.addr, v.wd, v.strb);
        if (v.wr) begin
            chk("awvalid_t1", {31'd0, awvalid}, 32'd1);
            chk("wvalid_t1", {31'd0, wvalid}, 32'd1);
            chk("awaddr_t1", awaddr, v.addr);
            chk("wdata_t1", wdata, v.wd);
            chk("wstrb_t1", {28'd0, wstrb}, {28'd0, v.strb});
            awready = 1'b1;
            wready  = 1'b1;
        end else begin
            chk("arvalid_t1", {31'd0, arvalid}, 32'd1);
            chk("araddr_t1", araddr, v.addr);
            arready = 1'b1;
        end
        step();
        awready = 1'b0;
        wready  = 1'b0;
        arready = 1'b0;
        if (v.wr) begin
            chk("bready_t2", {31'd0, bready}, 32'd1);
            chk("awvalid_t2", {31'd0, awvalid}, 32'd0);
            bvalid = 1'b1;
            bresp  = v.slv_resp;
        end else begin
            chk("rready_t2", {31'd0, rready}, 32'd1);
            chk("arvalid_t2", {31'd0, arvalid}, 32'd0);
            rvalid = 1'b1;
            rdata  = v.slv_rdata;
            rresp  = v.slv_resp;
        end
        chk("rsp_valid_t2", {31'd0, rsp_valid}, 32'd0);
        step();
        bvalid = 1'b0;
        rvalid = 1'b0;
        rdata  = 32'hBAD0_BAD0;
        chk("rsp_valid_t3", {31'd0, rsp_valid}, 32'd1);
        chk("rsp_rdata", rsp_rdata, v.exp_rdata);
        chk("rsp_resp", {30'd0, rsp_resp}, {30'd0, v.exp_resp});
        chk("rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
        chk("cmd_ready_in_rsp", {31'd0, cmd_ready}, 32'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("rsp_valid_after", {31'd0, rsp_valid}, 32'd0);
        chk("cmd_ready_after", {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 2'b00, 32'h0, 2'b00};
        vecs[1] = '{1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 2'b00, 32'hDEADBEEF, 2'b00};
        vecs[2] = '{1'b1, 32'h24, 32'h12345678, 4'h3, 32'h0, 2'b10, 32'h0, 2'b10};
        vecs[3] = '{1'b0, 32'h100, 32'h0, 4'h0, 32'hA5A5_0F0F, 2'b11, 32'hA5A5_0F0F, 2'b11};

        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;
        step();
        step();
        chk("rst_awvalid", {31'd0, awvalid}, 32'd0);
        chk("rst_wvalid", {31'd0, wvalid}, 32'd0);
        chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
        chk("rst_bready", {31'd0, bready}, 32'd0);
        chk("rst_rready", {31'd0, rready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Unexpected B/R beats while idle are not acknowledged.
        bvalid = 1'b1;
        rvalid = 1'b1;
        #1;
        chk("unexp_bready", {31'd0, bready}, 32'd0);
        chk("unexp_rready", {31'd0, rready}, 32'd0);
        step();
        bvalid = 1'b0;
        rvalid = 1'b0;
        chk("unexp_no_rsp", {31'd0, rsp_valid}, 32'd0);

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // Skewed write: wready immediate, awready after 5 waiting cycles.
        issue(1'b1, 32'h44, 32'hCAFE_F00D, 4'h5);
        for (int i = 0; i < 6; i++) begin
            chk("skew_awvalid", {31'd0, awvalid}, 32'd1);
            chk("skew_awaddr", awaddr, 32'h44);
            chk("skew_wvalid", {31'd0, wvalid}, (i == 0) ? 32'd1 : 32'd0);
            chk("skew_bready", {31'd0, bready}, 32'd0);
            wready  = (i == 0);
            awready = (i == 5);
            step();
        end
        awready = 1'b0;
        wready  = 1'b0;
        chk("skew_aw_drop", {31'd0, awvalid}, 32'd0);
        chk("skew_bready_on", {31'd0, bready}, 32'd1);
        bvalid = 1'b1;
        bresp  = 2'b00;
        step();
        bvalid = 1'b0;
        chk("skew_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("skew_bready_off", {31'd0, bready}, 32'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("skew_idle", {31'd0, cmd_ready}, 32'd1);

        // Read timeout: responder never answers.
        issue(1'b0, 32'h80, 32'h0, 4'h0);
        arready = 1'b1;
        step();
        arready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("tmo_rready", {31'd0, rready}, 32'd1);
            chk("tmo_no_rsp", {31'd0, rsp_valid}, 32'd0);
            step();
        end
        chk("tmo_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("tmo_flag", {31'd0, rsp_timeout}, 32'd1);
        chk("tmo_resp", {30'd0, rsp_resp}, 32'd2);
        chk("tmo_rdata", rsp_rdata, 32'd0);
        chk("tmo_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stale_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            chk("stale_rready", {31'd0, rready}, 32'd1);
            chk("stale_busy", {31'd0, busy}, 32'd1);
            chk("stale_no_rsp", {31'd0, rsp_valid}, 32'd0);
            step();
        end
        rvalid = 1'b1;
        rdata  = 32'h1111_2222;
        step();
        rvalid = 1'b0;
        chk("drain_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("drain_rready", {31'd0, rready}, 32'd0);
        chk("drain_no_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("drain_busy", {31'd0, busy}, 32'd0);

        // Response backpressure.
        issue(1'b1, 32'hC0, 32'h0BAD_F00D, 4'hF);
        awready = 1'b1;
        wready  = 1'b1;
        step();
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b1;
        bresp   = 2'b01;
        step();
        bvalid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rsp_resp", {30'd0, rsp_resp}, 32'd1);
            chk("bp_rsp_rdata", rsp_rdata, 32'd0);
            chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("bp_cmd_ready_after", {31'd0, cmd_ready}, 32'd1);

        // Reset in the middle of a write request.
        issue(1'b1, 32'hE0, 32'h5555_AAAA, 4'hF);
        chk("mid_awvalid", {31'd0, awvalid}, 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_awvalid_0", {31'd0, awvalid}, 32'd0);
        chk("mid_wvalid_0", {31'd0, wvalid}, 32'd0);
        chk("mid_rsp_valid_0", {31'd0, rsp_valid}, 32'd0);
        chk("mid_busy_0", {31'd0, busy}, 32'd0);
        chk("mid_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        step();
        chk("mid_still_idle", {31'd0, rsp_valid}, 32'd0);

        // Normal operation after the abort.
        run_vec(vecs[3]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cl_axil_cmd_master.md
Name: cl_axil_cmd_master

Overview:
- AXI-Lite initiator (master) for the CL. Converts a simple valid/ready command/response interface into single-beat AXI-Lite read and write transactions.
- Targets AXI-Lite responders such as the OCL register-slice/RAM path, and also serves as a CL-side bus-functional driver.
- One transaction outstanding at a time.
- A per-transaction response timeout keeps a hung responder from stalling the command side silently.

Parameters:
- ADDR_WIDTH, 32: AXI address width. cmd_addr is passed through unmodified.
- TIMEOUT_CYCLES, 1024: response-phase timeout in clk_main_a0 cycles. 0 disables the timeout. Counter width is clog2(TIMEOUT_CYCLES+1).

Ports:
- clk_main_a0  in  1  sole clock; all logic on rising edge
- rst_main_n  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  32  write data
- cmd_wstrb  in  4  write strobes
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_rdata  out  32  read data; 0 for writes and timeouts
- rsp_resp  out  2  BRESP/RRESP; 2'b10 on timeout
- rsp_timeout  out  1  response generated by timeout
- busy  out  1  state != IDLE or a stale flag is set
- m_axi_awvalid/awaddr[ADDR_WIDTH]/awready  out/out/in  write address channel
- m_axi_wvalid/wdata[32]/wstrb[4]/wready  out/out/out/in  write data channel
- m_axi_bvalid/bresp[2]/bready  in/in/out  write response channel
- m_axi_arvalid/araddr[ADDR_WIDTH]/arready  out/out/in  read address channel
- m_axi_rvalid/rdata[32]/rresp[2]/rready  in/in/in/out  read data channel

Behaviour:
- Reset (rst_main_n=0 at a clock edge):
  - State goes to IDLE. Stale flags and the timeout counter clear.
  - All m_axi valid/ready outputs, rsp_valid, rsp_timeout, rsp_rdata and rsp_resp are 0.
  - Reset mid-transaction aborts it immediately, with no response.
- cmd_ready is combinational: (state==IDLE) & !stale_b & !stale_r.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE:
  - On a write accept at cycle T, register addr/data/strb. At T+1 the state is WR_REQ with awvalid=wvalid=1.
  - A read accept behaves the same way, entering RD_REQ with arvalid=1.
- WR_REQ:
  - AW and W complete independently. awvalid drops the cycle after awready sampled high; wvalid drops the cycle after wready sampled high.
  - Valids are never withdrawn before their handshake. Address and data are stable while valid.
  - When both have completed (including completing in the same cycle), go to WR_RESP with bready=1.
- RD_REQ: arvalid is held until arready; then go to RD_DATA with rready=1.
- WR_RESP / RD_DATA:
  - Timeout counter clears on entry and increments each cycle.
  - B/R handshake: capture bresp, or rresp and rdata. Go to RSP with rsp_timeout=0. bready/rready go low on the same transition.
  - If the counter reaches TIMEOUT_CYCLES with no handshake, go to RSP with rsp_timeout=1, rsp_resp=2'b10 and rsp_rdata=0. Set stale_b or stale_r.
  - Handshake and expiry in the same cycle: the handshake wins and no stale flag is set.
- RSP:
  - rsp_valid=1 with fields stable until rsp_ready. Return to IDLE on the handshake.
  - The earliest next cmd_ready is the following cycle.
- Stale handling:
  - While stale_b is set, bready=1 in every state. The next bvalid is consumed and discarded, and stale_b clears.
  - stale_r and rready behave the same way.
  - Commands are blocked while either stale flag is set.
- Minimum latency, zero-wait responder:
  - Write: cmd accept T, AW/W handshake T+1, B handshake T+2, rsp_valid T+3.
  - Read: the same timing.
- Unexpected bvalid/rvalid when neither expected nor stale: ignored, with ready held 0.

Test Plan:
- Write, zero-wait responder: cmd addr=0x10, wdata=0xDEADBEEF, wstrb=0xF -> AW/W at T+1 carry 0x10/0xDEADBEEF/0xF; rsp_valid at T+3 with resp=0, rdata=0, timeout=0.
- Read back: cmd read addr=0x10, responder returns rdata=0xDEADBEEF, rresp=0 -> rsp_rdata=0xDEADBEEF, resp=0.
- Skewed write handshakes: awready delayed 5 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 6 cycles with stable addr; one B accepted.
- Timeout: TIMEOUT_CYCLES=8, responder never asserts rvalid -> rsp after 8 cycles in RD_DATA with timeout=1, resp=2'b10; cmd_ready stays 0. Late rvalid is drained with no rsp; cmd_ready returns to 1.
- Response backpressure: rsp_ready held 0 for 10 cycles -> rsp fields stable, cmd_ready=0 throughout; after the handshake, cmd_ready=1 the next cycle.
- Reset mid-op: drop rst_main_n for 1 cycle while in WR_REQ -> all valids 0 the next cycle, state IDLE, no rsp_valid, busy=0.
